// File: rtl/register_arbiter_if.sv
// register_arbiter_if: requester-side handshake plus the pins of the shared Register.
interface register_arbiter_if #(
    parameter int N = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic               busy;
    logic [WIDTH-1:0]   rdata;
    logic [WIDTH-1:0]   reg_in;
    logic               reg_load;
    logic [WIDTH-1:0]   reg_out;

    modport master (
        output req, wdata, reg_out,
        input  gnt, ack, busy, rdata, reg_in, reg_load
    );

    modport slave (
        input  req, wdata, reg_out,
        output gnt, ack, busy, rdata, reg_in, reg_load
    );
endinterface

// File: rtl/register_arbiter.sv
// register_arbiter: round-robin write arbiter sequencing IDLE -> LOAD -> ACK into one shared Register.
module register_arbiter #(
    parameter int N = 4,
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic reset,
    register_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t           state, next;
    logic [PW-1:0]    ptr, win, pick, idx;
    logic [WIDTH-1:0] dreg;

    // Scan downward so the requester closest above ptr is the last to overwrite pick.
    always_comb begin
        pick = ptr;
        idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (bus.req[idx]) pick = idx;
        end
    end

    always_comb begin
        next = IDLE;
        next = (state == IDLE) ? ((|bus.req) ? LOAD : IDLE) : (state == LOAD) ? ACK : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            dreg  <= '0;
        end else begin
            state <= next;
            if (state == IDLE && |bus.req) begin
                win  <= pick;
                dreg <= bus.wdata[pick*WIDTH +: WIDTH];
            end
            if (state == ACK) ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    // Outputs decode from state, so an asynchronous reset clears them immediately.
    assign bus.gnt      = (state != IDLE) ? N'(1) << win : '0;
    assign bus.ack      = (state == ACK) ? N'(1) << win : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.reg_load = (state == LOAD);
    assign bus.reg_in   = dreg;
    assign bus.rdata    = bus.reg_out;
endmodule

// File: tb/tb_register_arbiter.sv
// tb_register_arbiter: directed and random writes checked against a round-robin reference model.
module tb_register_arbiter;
    localparam int N = 4;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [WIDTH-1:0] reg_q = '0;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ptr_m = 0;
    int ack_cyc = 0;
    logic [WIDTH-1:0] reg_m = '0;
    logic [WIDTH-1:0] dat [N];

    register_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    register_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.reg_load) reg_q <= bus.reg_in;
    end

    assign bus.reg_out = reg_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) bus.wdata[i*WIDTH +: WIDTH] = dat[i];
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    task automatic do_write(input logic [N-1:0] r, input logic keep, output int w);
        logic [N-1:0] oh;
        bus.req = r;
        drive_data();
        w = model_pick(r, ptr_m);
        oh = N'(1) << w;
        @(negedge clk);
        chk("load_reg_load", 64'(bus.reg_load), 64'(1));
        chk("load_reg_in", 64'(bus.reg_in), 64'(dat[w]));
        chk("load_gnt", 64'(bus.gnt), 64'(oh));
        chk("load_ack", 64'(bus.ack), 64'(0));
        chk("load_busy", 64'(bus.busy), 64'(1));
        if (!keep) begin
            bus.req = '0;
            for (int i = 0; i < N; i++) bus.wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        @(negedge clk);
        chk("ack_ack", 64'(bus.ack), 64'(oh));
        chk("ack_gnt", 64'(bus.gnt), 64'(oh));
        chk("ack_reg_load", 64'(bus.reg_load), 64'(0));
        chk("ack_rdata", 64'(bus.rdata), 64'(dat[w]));
        reg_m = dat[w];
        ptr_m = (w + 1) % N;
        ack_cyc = cyc;
        @(negedge clk);
        chk("idle_busy", 64'(bus.busy), 64'(0));
        chk("idle_gnt", 64'(bus.gnt), 64'(0));
        chk("idle_ack", 64'(bus.ack), 64'(0));
    endtask

    initial begin
        int w;
        int prev;
        bus.req = '1;
        bus.wdata = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 64'(bus.gnt), 64'(0));
            chk("rst_ack", 64'(bus.ack), 64'(0));
            chk("rst_reg_load", 64'(bus.reg_load), 64'(0));
            chk("rst_busy", 64'(bus.busy), 64'(0));
            chk("rst_reg_in", 64'(bus.reg_in), 64'(0));
        end
        reset = 1'b0;

        for (int i = 0; i < N; i++) dat[i] = WIDTH'(16'h1111 * (i + 1) + 16'h0a05);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            do_write('1, 1'b1, w);
            chk("fair_order", 64'(w), 64'(i % N));
            if (i > 0) chk("fair_spacing", 64'(ack_cyc - prev), 64'(3));
            prev = ack_cyc;
        end

        dat[2] = 16'h1234;
        do_write(4'b0100, 1'b0, w);
        chk("single_win", 64'(w), 64'(2));

        do_write(4'b1000, 1'b0, w);
        do_write(4'b0011, 1'b1, w);
        chk("wrap_first", 64'(w), 64'(0));
        do_write(4'b0011, 1'b0, w);
        chk("wrap_second", 64'(w), 64'(1));

        dat[1] = 16'hFFFF;
        do_write(4'b0010, 1'b0, w);
        chk("signed_m1", 64'($signed(bus.rdata)), 64'(-1));
        dat[0] = 16'h8000;
        do_write(4'b0001, 1'b0, w);
        chk("signed_min", 64'($signed(bus.rdata)), 64'(-32768));

        dat[2] = 16'h5a5a;
        bus.req = 4'b0100;
        drive_data();
        @(negedge clk);
        chk("mid_load_before", 64'(bus.reg_load), 64'(1));
        #1 reset = 1'b1;
        #1;
        chk("mid_load_async", 64'(bus.reg_load), 64'(0));
        chk("mid_gnt_async", 64'(bus.gnt), 64'(0));
        #1 reset = 1'b0;
        bus.req = '0;
        ptr_m = 0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_ack", 64'(bus.ack), 64'(0));
            chk("mid_retain", 64'(bus.rdata), 64'(reg_m));
        end
        do_write(4'b1001, 1'b0, w);
        chk("mid_ptr_reset", 64'(w), 64'(0));

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) dat[i] = WIDTH'($urandom);
            do_write(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)), w);
        end
        bus.req = '0;
        @(negedge clk);
        chk("final_rdata", 64'(bus.rdata), 64'(reg_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
